// File: rtl/ps2_kbd_decoder.sv
// ---------------------------------------------------------------------------
// ps2_kbd_decoder
//  PS/2 keyboard front end for the terminal. Receives scan-code-set-2 frames,
//  validates start/parity/stop and the inter-edge timeout, tracks the E0/F0
//  prefixes and the Shift/Ctrl modifiers, translates key-down events to 8-bit
//  terminal codes and queues them in a FIFO drained over valid/ready.
//
//  Ports
//   px_clk     in   1  system clock, all logic on posedge
//   clr        in   1  asynchronous reset, active-high
//   ps2_clk    in   1  raw PS/2 clock (asynchronous)
//   ps2_data   in   1  raw PS/2 data (asynchronous)
//   key_data   out  8  FIFO head code, valid while key_valid=1
//   key_valid  out  1  FIFO not empty
//   key_ready  in   1  consumer accepts head when key_valid & key_ready
//   shift      out  1  left or right Shift held
//   ctrl       out  1  left or right Ctrl held
//   frame_err  out  1  one-cycle pulse on bad parity, bad stop bit or timeout
//   overflow   out  1  sticky, a code was dropped on a full FIFO
//   ovf_clr    in   1  synchronous clear of overflow (wins over a new drop)
//
//  Latency: the stop bit is seen in cycle N, the byte is translated in N+1,
//  written to the FIFO at the end of N+2 and visible on key_valid in N+3.
// ---------------------------------------------------------------------------
module ps2_kbd_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT     = 32768
) (
    input  logic       px_clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shift,
    output logic       ctrl,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Scan code translation helpers
    // -----------------------------------------------------------------------

    // US layout, returns {hit, unshifted glyph, shifted glyph}
    function automatic logic [16:0] us_xlate(input logic [7:0] sc);
        case (sc)
            8'h1C: us_xlate = {1'b1, 8'h61, 8'h41};  // a
            8'h32: us_xlate = {1'b1, 8'h62, 8'h42};  // b
            8'h21: us_xlate = {1'b1, 8'h63, 8'h43};  // c
            8'h23: us_xlate = {1'b1, 8'h64, 8'h44};  // d
            8'h24: us_xlate = {1'b1, 8'h65, 8'h45};  // e
            8'h2B: us_xlate = {1'b1, 8'h66, 8'h46};  // f
            8'h34: us_xlate = {1'b1, 8'h67, 8'h47};  // g
            8'h33: us_xlate = {1'b1, 8'h68, 8'h48};  // h
            8'h43: us_xlate = {1'b1, 8'h69, 8'h49};  // i
            8'h3B: us_xlate = {1'b1, 8'h6A, 8'h4A};  // j
            8'h42: us_xlate = {1'b1, 8'h6B, 8'h4B};  // k
            8'h4B: us_xlate = {1'b1, 8'h6C, 8'h4C};  // l
            8'h3A: us_xlate = {1'b1, 8'h6D, 8'h4D};  // m
            8'h31: us_xlate = {1'b1, 8'h6E, 8'h4E};  // n
            8'h44: us_xlate = {1'b1, 8'h6F, 8'h4F};  // o
            8'h4D: us_xlate = {1'b1, 8'h70, 8'h50};  // p
            8'h15: us_xlate = {1'b1, 8'h71, 8'h51};  // q
            8'h2D: us_xlate = {1'b1, 8'h72, 8'h52};  // r
            8'h1B: us_xlate = {1'b1, 8'h73, 8'h53};  // s
            8'h2C: us_xlate = {1'b1, 8'h74, 8'h54};  // t
            8'h3C: us_xlate = {1'b1, 8'h75, 8'h55};  // u
            8'h2A: us_xlate = {1'b1, 8'h76, 8'h56};  // v
            8'h1D: us_xlate = {1'b1, 8'h77, 8'h57};  // w
            8'h22: us_xlate = {1'b1, 8'h78, 8'h58};  // x
            8'h35: us_xlate = {1'b1, 8'h79, 8'h59};  // y
            8'h1A: us_xlate = {1'b1, 8'h7A, 8'h5A};  // z
            8'h16: us_xlate = {1'b1, 8'h31, 8'h21};  // 1 !
            8'h1E: us_xlate = {1'b1, 8'h32, 8'h40};  // 2 @
            8'h26: us_xlate = {1'b1, 8'h33, 8'h23};  // 3 #
            8'h25: us_xlate = {1'b1, 8'h34, 8'h24};  // 4 $
            8'h2E: us_xlate = {1'b1, 8'h35, 8'h25};  // 5 %
            8'h36: us_xlate = {1'b1, 8'h36, 8'h5E};  // 6 ^
            8'h3D: us_xlate = {1'b1, 8'h37, 8'h26};  // 7 &
            8'h3E: us_xlate = {1'b1, 8'h38, 8'h2A};  // 8 *
            8'h46: us_xlate = {1'b1, 8'h39, 8'h28};  // 9 (
            8'h45: us_xlate = {1'b1, 8'h30, 8'h29};  // 0 )
            8'h0E: us_xlate = {1'b1, 8'h60, 8'h7E};  // ` ~
            8'h4E: us_xlate = {1'b1, 8'h2D, 8'h5F};  // - _
            8'h55: us_xlate = {1'b1, 8'h3D, 8'h2B};  // = +
            8'h54: us_xlate = {1'b1, 8'h5B, 8'h7B};  // [ {
            8'h5B: us_xlate = {1'b1, 8'h5D, 8'h7D};  // ] }
            8'h5D: us_xlate = {1'b1, 8'h5C, 8'h7C};  // backslash |
            8'h4C: us_xlate = {1'b1, 8'h3B, 8'h3A};  // ; :
            8'h52: us_xlate = {1'b1, 8'h27, 8'h22};  // quote, double quote
            8'h41: us_xlate = {1'b1, 8'h2C, 8'h3C};  // , <
            8'h49: us_xlate = {1'b1, 8'h2E, 8'h3E};  // . >
            8'h4A: us_xlate = {1'b1, 8'h2F, 8'h3F};  // / ?
            8'h5A: us_xlate = {1'b1, 8'h0D, 8'h0D};  // Enter
            8'h66: us_xlate = {1'b1, 8'h08, 8'h08};  // Backspace
            8'h0D: us_xlate = {1'b1, 8'h09, 8'h09};  // Tab
            8'h76: us_xlate = {1'b1, 8'h1B, 8'h1B};  // Esc
            8'h29: us_xlate = {1'b1, 8'h20, 8'h20};  // Space
            default: us_xlate = {1'b0, 8'h00, 8'h00};
        endcase
    endfunction

    // E0-prefixed cursor keys, returns {hit, code}
    function automatic logic [8:0] ext_xlate(input logic [7:0] sc);
        case (sc)
            8'h75:   ext_xlate = {1'b1, 8'h80};  // up
            8'h72:   ext_xlate = {1'b1, 8'h81};  // down
            8'h6B:   ext_xlate = {1'b1, 8'h82};  // left
            8'h74:   ext_xlate = {1'b1, 8'h83};  // right
            default: ext_xlate = {1'b0, 8'h00};
        endcase
    endfunction

    // Ctrl beats Shift; Ctrl+letter is the uppercase letter masked to 5 bits,
    // which equals the lowercase glyph masked the same way.
    function automatic logic [7:0] apply_mods(input logic [7:0] plain,
                                              input logic [7:0] shifted,
                                              input logic       sh,
                                              input logic       ct);
        if (ct && (plain >= 8'h61) && (plain <= 8'h7A)) begin
            apply_mods = plain & 8'h1F;
        end else if (sh) begin
            apply_mods = shifted;
        end else begin
            apply_mods = plain;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   clk_prev_r;
    logic                   fall_s;
    logic                   bit_s;

    // Synchronise both PS/2 lines; reset to the idle-high bus level
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            clk_sync_r <= '1;
            dat_sync_r <= '1;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign bit_s  = dat_sync_r[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Frame receiver
    // -----------------------------------------------------------------------
    state_t        state_r;
    state_t        state_s;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shreg_r;
    logic          parity_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_s;
    logic          stop_ok_s;
    logic          good_s;
    logic          bad_s;
    logic [7:0]    byte_r;
    logic          byte_stb_r;
    logic          frame_err_r;

    // Frame FSM next state plus good/bad frame classification
    always_comb begin
        state_s   = state_r;
        timeout_s = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT - 1));
        stop_ok_s = bit_s & (^{shreg_r, parity_r});
        good_s    = 1'b0;
        bad_s     = timeout_s;
        case (state_r)
            ST_IDLE: begin
                if (fall_s && !bit_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (timeout_s) begin
                    state_s = ST_IDLE;
                end else if (fall_s && (bit_cnt_r == 3'd7)) begin
                    state_s = ST_PARITY;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (timeout_s) begin
                    state_s = ST_IDLE;
                end else if (fall_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (timeout_s) begin
                    state_s = ST_IDLE;
                end else if (fall_s) begin
                    state_s = ST_IDLE;
                    good_s  = stop_ok_s;
                    bad_s   = !stop_ok_s;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state register, bit shifter, timeout counter, byte strobe
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shreg_r     <= 8'h00;
            parity_r    <= 1'b0;
            tmo_cnt_r   <= '0;
            byte_r      <= 8'h00;
            byte_stb_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if ((state_r == ST_DATA) && fall_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if ((state_r == ST_DATA) && fall_s) begin
                shreg_r <= {bit_s, shreg_r[7:1]};
            end else begin
                shreg_r <= shreg_r;
            end
            if ((state_r == ST_PARITY) && fall_s) begin
                parity_r <= bit_s;
            end else begin
                parity_r <= parity_r;
            end
            // Reloads on every fall; only counts while a frame is open
            if (fall_s || (state_r == ST_IDLE)) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            if (good_s) begin
                byte_r <= shreg_r;
            end else begin
                byte_r <= byte_r;
            end
            byte_stb_r  <= good_s;
            frame_err_r <= bad_s;
        end
    end

    // -----------------------------------------------------------------------
    // Prefix / modifier tracking and translation
    // -----------------------------------------------------------------------
    logic        ext_r, brk_r, lsh_r, rsh_r, lct_r, rct_r;
    logic        ext_s, brk_s, lsh_s, rsh_s, lct_s, rct_s;
    logic        shift_r, ctrl_r;
    logic        push_s;
    logic [7:0]  code_s;
    logic        push_r;
    logic [7:0]  push_code_r;
    logic [16:0] us_s;
    logic [8:0]  ex_s;

    assign us_s = us_xlate(byte_r);
    assign ex_s = ext_xlate(byte_r);

    // Decode one received byte against the current prefix and modifier state
    always_comb begin
        ext_s  = ext_r;
        brk_s  = brk_r;
        lsh_s  = lsh_r;
        rsh_s  = rsh_r;
        lct_s  = lct_r;
        rct_s  = rct_r;
        push_s = 1'b0;
        code_s = 8'h00;
        if (byte_stb_r) begin
            if (byte_r == 8'hE0) begin
                ext_s = 1'b1;
            end else if (byte_r == 8'hF0) begin
                brk_s = 1'b1;
            end else begin
                ext_s = 1'b0;
                brk_s = 1'b0;
                if (ext_r) begin
                    if (byte_r == 8'h14) begin
                        rct_s = !brk_r;
                    end else if (!brk_r) begin
                        push_s = ex_s[8];
                        code_s = ex_s[7:0];
                    end else begin
                        push_s = 1'b0;
                    end
                end else begin
                    case (byte_r)
                        8'h12: lsh_s = !brk_r;
                        8'h59: rsh_s = !brk_r;
                        8'h14: lct_s = !brk_r;
                        default: begin
                            if (!brk_r) begin
                                push_s = us_s[16];
                                code_s = apply_mods(us_s[15:8], us_s[7:0], shift_r, ctrl_r);
                            end else begin
                                push_s = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Register decoder state and the pending FIFO write
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            lsh_r       <= 1'b0;
            rsh_r       <= 1'b0;
            lct_r       <= 1'b0;
            rct_r       <= 1'b0;
            shift_r     <= 1'b0;
            ctrl_r      <= 1'b0;
            push_r      <= 1'b0;
            push_code_r <= 8'h00;
        end else begin
            ext_r       <= ext_s;
            brk_r       <= brk_s;
            lsh_r       <= lsh_s;
            rsh_r       <= rsh_s;
            lct_r       <= lct_s;
            rct_r       <= rct_s;
            shift_r     <= lsh_s | rsh_s;
            ctrl_r      <= lct_s | rct_s;
            push_r      <= push_s;
            push_code_r <= code_s;
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO with registered head
    // -----------------------------------------------------------------------
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_s;
    logic [7:0]    key_data_r, head_s;
    logic          key_valid_r;
    logic          overflow_r;
    logic          pop_s, full_s, wr_en_s, drop_s;

    assign pop_s   = key_valid_r & key_ready;
    assign full_s  = (count_r == CW'(FIFO_DEPTH));
    assign wr_en_s = push_r & (!full_s | pop_s);
    assign drop_s  = push_r & full_s & !pop_s;

    // Next occupancy and next head value (bypass when the write becomes head)
    always_comb begin
        case ({wr_en_s, pop_s})
            2'b10:   count_s = count_r + CW'(1);
            2'b01:   count_s = count_r - CW'(1);
            default: count_s = count_r;
        endcase
        if (pop_s) begin
            if (count_r > CW'(1)) begin
                head_s = mem_r[rd_ptr_r + PW'(1)];
            end else if (wr_en_s) begin
                head_s = push_code_r;
            end else begin
                head_s = key_data_r;
            end
        end else if ((count_r == CW'(0)) && wr_en_s) begin
            head_s = push_code_r;
        end else begin
            head_s = key_data_r;
        end
    end

    // FIFO storage, pointers, head/valid registers and sticky overflow
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            key_data_r  <= 8'h00;
            key_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_code_r;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_s;
            key_data_r  <= head_s;
            key_valid_r <= (count_s != CW'(0));
            if (ovf_clr) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign key_data  = key_data_r;
    assign key_valid = key_valid_r;
    assign shift     = shift_r;
    assign ctrl      = ctrl_r;
    assign frame_err = frame_err_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_decoder
//  Drives PS/2 frames into ps2_kbd_decoder. A reference keyboard model built
//  from layout strings predicts each terminal code and pushes it into a queue;
//  a monitor pops and compares whenever the DUT hands over a code.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_decoder;

    localparam int S     = 2;    // synchroniser stages
    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int H     = 8;    // px_clk cycles per PS/2 half phase

    logic       px_clk = 1'b0;
    logic       clr, ps2_clk, ps2_data, key_ready, key_valid;
    logic       shift, ctrl, frame_err, overflow, ovf_clr;
    logic [7:0] key_data;
    logic       rnd_en, rnd_ready, man_ready;

    assign key_ready = rnd_en ? rnd_ready : man_ready;

    always #5 px_clk = ~px_clk;

    ps2_kbd_decoder #(.SYNC_STAGES(S), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .px_clk(px_clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .shift(shift), .ctrl(ctrl), .frame_err(frame_err), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         err_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    // reference model state
    logic [7:0] lo_map[logic [7:0]];
    logic [7:0] hi_map[logic [7:0]];
    logic [7:0] arrow_map[logic [7:0]];
    bit m_ext, m_brk, m_lsh, m_rsh, m_lct, m_rct;
    bit exp_ovf, allow_full;

    logic [7:0] sc_let [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                8'h35, 8'h1A};
    logic [7:0] sc_dig [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h45};
    logic [7:0] sc_pun [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A};
    logic [7:0] pun_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                8'h2C, 8'h2E, 8'h2F};
    logic [7:0] pun_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                8'h3C, 8'h3E, 8'h3F};
    logic [7:0] pool [20]   = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h0E, 8'h52, 8'h4A,
                                8'h5A, 8'h66, 8'h0D, 8'h76, 8'h29, 8'h4D, 8'h1A, 8'h05,
                                8'h58, 8'h11, 8'h2B, 8'h55};
    logic [7:0] ext_pool [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h70, 8'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compare every handed-over code with the queue head
    always @(negedge px_clk) begin
        if (!clr) begin
            if (frame_err) err_cnt++;
            if (key_valid && key_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL key_data: got %02h, expected no code", key_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (key_data !== mon_exp) begin
                        n_fail++;
                        $display("FAIL key_data: got %02h, expected %02h", key_data, mon_exp);
                    end
                end
            end
        end
    end

    always begin
        @(posedge px_clk);
        #1 rnd_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic build_maps();
        string let_s, dig_lo, dig_hi;
        let_s  = "abcdefghijklmnopqrstuvwxyz";
        dig_lo = "1234567890";
        dig_hi = "!@#$%^&*()";
        for (int i = 0; i < 26; i++) begin
            lo_map[sc_let[i]] = let_s[i];
            hi_map[sc_let[i]] = let_s[i] - 8'd32;
        end
        for (int i = 0; i < 10; i++) begin
            lo_map[sc_dig[i]] = dig_lo[i];
            hi_map[sc_dig[i]] = dig_hi[i];
        end
        for (int i = 0; i < 11; i++) begin
            lo_map[sc_pun[i]] = pun_lo[i];
            hi_map[sc_pun[i]] = pun_hi[i];
        end
        lo_map[8'h5A] = 8'h0D; hi_map[8'h5A] = 8'h0D;
        lo_map[8'h66] = 8'h08; hi_map[8'h66] = 8'h08;
        lo_map[8'h0D] = 8'h09; hi_map[8'h0D] = 8'h09;
        lo_map[8'h76] = 8'h1B; hi_map[8'h76] = 8'h1B;
        lo_map[8'h29] = 8'h20; hi_map[8'h29] = 8'h20;
        arrow_map[8'h75] = 8'h80; arrow_map[8'h72] = 8'h81;
        arrow_map[8'h6B] = 8'h82; arrow_map[8'h74] = 8'h83;
    endtask

    task automatic model_push(input logic [7:0] c);
        if (exp_q.size() >= DEPTH && !allow_full) exp_ovf = 1'b1;
        else exp_q.push_back(c);
    endtask

    task automatic model_reset();
        exp_q.delete();
        {m_ext, m_brk, m_lsh, m_rsh, m_lct, m_rct} = 6'b0;
        exp_ovf = 1'b0;
    endtask

    // keyboard behaviour for one accepted byte
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] ch;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_ext) begin
                if (b == 8'h14) m_rct = !m_brk;
                else if (!m_brk && arrow_map.exists(b)) model_push(arrow_map[b]);
            end else if (b == 8'h12) m_lsh = !m_brk;
            else if (b == 8'h59) m_rsh = !m_brk;
            else if (b == 8'h14) m_lct = !m_brk;
            else if (!m_brk && lo_map.exists(b)) begin
                ch = lo_map[b];
                if ((m_lct || m_rct) && ch >= "a" && ch <= "z") model_push((ch - 8'd32) % 8'd32);
                else if (m_lsh || m_rsh) model_push(hi_map[b]);
                else model_push(ch);
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        repeat (H) @(posedge px_clk);
        #1 ps2_data = v;
        repeat (H) @(posedge px_clk);
        #1 ps2_clk = 1'b0;
        repeat (H) @(posedge px_clk);
        #1 ps2_clk = 1'b1;
    endtask

    // full frame; optional latency check or a ready pulse aligned to the FIFO write
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit chk_lat, input bit pop_full);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        repeat (H) @(posedge px_clk);
        #1 ps2_data = bits[10];
        repeat (H) @(posedge px_clk);
        #1 ps2_clk = 1'b0;
        for (int c = 1; c <= H; c++) begin
            @(posedge px_clk);
            #1;
            if (chk_lat && c == S + 2) check("latency_early", key_valid, 1'b0);
            if (chk_lat && c == S + 3) check("latency_valid", key_valid, 1'b1);
            if (pop_full) man_ready = (c == S + 2);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
    endtask

    task automatic press(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
        check("shift", shift, m_lsh | m_rsh);
        check("ctrl", ctrl, m_lct | m_rct);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rnd_en = 1'b1;
        while ((exp_q.size() != 0 || key_valid) && t < 1000) begin
            @(posedge px_clk);
            #1 t++;
        end
        check("drain_left", exp_q.size() + key_valid, 0);
        rnd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] c, last;
        int e0;
        clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        man_ready = 1'b0; rnd_en = 1'b0; ovf_clr = 1'b0; allow_full = 1'b0;
        last = 8'h1C;
        build_maps();
        model_reset();
        repeat (3) @(posedge px_clk);
        #1;
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_data", key_data, 8'h00);
        check("rst_shift", shift, 1'b0);
        check("rst_ctrl", ctrl, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        clr = 1'b0;

        // single key, exact latency, ready low
        model_byte(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_key_data", key_data, 8'h61);
        drain();

        // shift make/break around a letter
        press(8'h12); press(8'h1C); press(8'hF0); press(8'h12); press(8'h1C);
        drain();

        // extended up arrow make and break, then plain key
        press(8'hE0); press(8'h75); press(8'hE0); press(8'hF0); press(8'h75); press(8'h1C);
        drain();

        // bad parity, bad stop
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge px_clk);
        #1;
        check("bad_frame_errs", err_cnt - e0, 2);
        check("bad_frame_empty", key_valid, 1'b0);

        // timeout mid-frame
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        repeat (TMO - H - 5) @(posedge px_clk);
        #1 check("tmo_not_yet", err_cnt - e0, 0);
        repeat (20) @(posedge px_clk);
        #1 check("tmo_err", err_cnt - e0, 1);
        press(8'h29);
        drain();

        // overflow: DEPTH+1 codes with ready low
        man_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) press(sc_let[i]);
        check("ovf_set", overflow, exp_ovf);
        // full: push and pop in the same cycle
        allow_full = 1'b1;
        model_byte(sc_let[20]);
        send_frame(sc_let[20], 1'b0, 1'b0, 1'b0, 1'b1);
        allow_full = 1'b0;
        check("ovf_sticky", overflow, 1'b1);
        check("full_valid", key_valid, 1'b1);
        @(posedge px_clk);
        #1 ovf_clr = 1'b1;
        @(posedge px_clk);
        #1 ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        drain();

        // reset mid-frame with data queued and shift held
        press(8'h12); press(8'h1C);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        #1 clr = 1'b1;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (2) @(posedge px_clk);
        #1;
        check("clr_key_valid", key_valid, 1'b0);
        check("clr_shift", shift, 1'b0);
        clr = 1'b0;
        press(8'h1C);
        drain();

        // randomized key traffic
        rnd_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    c = pool[$urandom_range(0, 19)];
                    press(c);
                    if ($urandom_range(0, 1) == 1) begin press(8'hF0); press(c); end
                    last = c;
                end
                5: begin
                    c = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
                    if ((c == 8'h12 && m_lsh) || (c == 8'h59 && m_rsh)) press(8'hF0);
                    press(c);
                end
                6: begin
                    if (m_lct) press(8'hF0);
                    press(8'h14);
                end
                7: begin
                    press(8'hE0);
                    if (m_rct) press(8'hF0);
                    press(8'h14);
                end
                8: begin
                    c = ext_pool[$urandom_range(0, 5)];
                    press(8'hE0); press(c);
                    if ($urandom_range(0, 1) == 1) begin press(8'hE0); press(8'hF0); press(c); end
                end
                default: press(last);
            endcase
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
